// File: rtl/prog_loader_if.sv
// Byte-stream input and main-store write port bundle for prog_loader.
//   in_data/in_valid/in_ready : valid/ready stream into the loader
//   ms_write/ms_addr/ms_data  : main-store write port out of the loader
// master = stream source / store side, slave = loader side.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ms_write;
  logic [ADDR_W-1:0] ms_addr;
  logic [DATA_W-1:0] ms_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, ms_write, ms_addr, ms_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ms_write, ms_addr, ms_data
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader. Accepts a LEN / data / CHK framed byte stream,
// writes the data into main store, zero-fills the remainder, and releases
// the core from reset only after the checksum matches.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   bus      : stream input + main-store write port (slave side)
//   reload   : 1-cycle pulse, restart load from RUN or ERROR
//   core_rst : active-low reset to the core, high only in RUN
//   done     : high in RUN
//   error    : high in ERROR
module prog_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic           clk,
  input  logic           rst,
  prog_loader_if.slave   bus,
  input  logic           reload,
  output logic           core_rst,
  output logic           done,
  output logic           error
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_CHECK, ST_FILL, ST_RUN, ST_ERROR
  } state_e;

  state_e            r_state,    w_state_nxt;
  logic [CNT_W-1:0]  r_len,      w_len_nxt;
  logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
  logic [DATA_W-1:0] r_sum,      w_sum_nxt;
  logic              r_ms_write, w_ms_write_nxt;
  logic [ADDR_W-1:0] r_ms_addr,  w_ms_addr_nxt;
  logic [DATA_W-1:0] r_ms_data,  w_ms_data_nxt;
  logic              r_in_ready, w_in_ready_nxt;
  logic              r_core_rst, w_core_rst_nxt;
  logic              r_done,     w_done_nxt;
  logic              r_error,    w_error_nxt;
  logic              w_xfer;
  logic              w_len_bad;

  // r_in_ready is a registered decode of the state, so it never depends on in_valid
  assign w_xfer    = bus.in_valid & r_in_ready;
  assign w_len_bad = (bus.in_data == '0) ||
                     ({1'b0, bus.in_data} > (DATA_W+1)'(DEPTH));

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_ms_write <= 1'b0;
      r_ms_addr  <= '0;
      r_ms_data  <= '0;
      r_in_ready <= 1'b1;
      r_core_rst <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sum      <= w_sum_nxt;
      r_ms_write <= w_ms_write_nxt;
      r_ms_addr  <= w_ms_addr_nxt;
      r_ms_data  <= w_ms_data_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_core_rst <= w_core_rst_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_cnt_nxt      = r_cnt;
    w_sum_nxt      = r_sum;
    w_ms_write_nxt = 1'b0;
    w_ms_addr_nxt  = r_ms_addr;
    w_ms_data_nxt  = r_ms_data;

    unique case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (w_len_bad) begin
            w_state_nxt = ST_ERROR;
          end else begin
            w_len_nxt   = CNT_W'(bus.in_data);
            w_cnt_nxt   = '0;
            w_sum_nxt   = '0;
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (w_xfer) begin
          w_ms_write_nxt = 1'b1;
          w_ms_addr_nxt  = r_cnt[ADDR_W-1:0];
          w_ms_data_nxt  = bus.in_data;
          w_sum_nxt      = r_sum + bus.in_data;
          w_cnt_nxt      = r_cnt + CNT_W'(1);
          if (w_cnt_nxt == r_len) w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_xfer) w_state_nxt = (bus.in_data == r_sum) ? ST_FILL : ST_ERROR;
      end
      ST_FILL: begin
        // A full-length image leaves nothing to fill
        if (r_cnt == CNT_W'(DEPTH)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_ms_write_nxt = 1'b1;
          w_ms_addr_nxt  = r_cnt[ADDR_W-1:0];
          w_ms_data_nxt  = '0;
          w_cnt_nxt      = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DEPTH - 1)) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (reload) w_state_nxt = ST_IDLE;
      end
      ST_ERROR: begin
        if (reload) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_in_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD) ||
                     (w_state_nxt == ST_CHECK);
    w_done_nxt     = (w_state_nxt == ST_RUN);
    w_error_nxt    = (w_state_nxt == ST_ERROR);
    // Core leaves reset one cycle after RUN entry and drops on the reload edge
    w_core_rst_nxt = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
  end

  assign bus.in_ready = r_in_ready;
  assign bus.ms_write = r_ms_write;
  assign bus.ms_addr  = r_ms_addr;
  assign bus.ms_data  = r_ms_data;
  assign core_rst     = r_core_rst;
  assign done         = r_done;
  assign error        = r_error;
endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reload = 1'b0;
  logic core_rst, done, error;

  int errors = 0;
  int checks = 0;

  logic [4:0] wr_addr[$];
  logic [7:0] wr_data[$];
  logic [7:0] exp_mem[32];

  prog_loader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  prog_loader #(.ADDR_W(5), .DATA_W(8), .DEPTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .reload   (reload),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Store-write monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst && bus.ms_write === 1'b1) begin
      wr_addr.push_back(bus.ms_addr);
      wr_data.push_back(bus.ms_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
  endtask

  // Drive one byte and hold it until the loader has taken it
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send ready timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h5C;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // Compare the captured write log against exp_mem in address order
  task automatic check_log(input string tag, input int exp_n);
    int bad;
    bad = 0;
    chk({tag, " count"}, 32'(wr_addr.size()), 32'(exp_n));
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (wr_addr[i] !== 5'(i) || wr_data[i] !== exp_mem[i]) bad++;
    end
    chk({tag, " image"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] s;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst ms_write", 32'(bus.ms_write), 32'd0);
    chk("rst ms_addr",  32'(bus.ms_addr),  32'd0);
    chk("rst ms_data",  32'(bus.ms_data),  32'd0);
    chk("rst core_rst", 32'(core_rst),     32'd0);
    chk("rst done",     32'(done),         32'd0);
    chk("rst error",    32'(error),        32'd0);
    rst = 1'b1;

    // 1: short frame, zero fill, RUN
    clear_log();
    exp_mem[0] = 8'hA1; exp_mem[1] = 8'h02; exp_mem[2] = 8'h03;
    send_byte(8'h03); send_byte(8'hA1); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'hA6);
    end_frame();
    chk("t1 fill in_ready", 32'(bus.in_ready), 32'd0);
    chk("t1 fill core_rst", 32'(core_rst), 32'd0);
    wait_done("t1 done");
    chk("t1 core_rst", 32'(core_rst), 32'd1);
    chk("t1 in_ready", 32'(bus.in_ready), 32'd0);
    check_log("t1", 32);
    pulse_reload();
    chk("t1 reload core_rst", 32'(core_rst), 32'd0);
    chk("t1 reload in_ready", 32'(bus.in_ready), 32'd1);

    // 2: bad checksum
    clear_log();
    exp_mem[0] = 8'hA1; exp_mem[1] = 8'h02; exp_mem[2] = 8'h03;
    send_byte(8'h03); send_byte(8'hA1); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'hA5);
    end_frame();
    chk("t2 error", 32'(error), 32'd1);
    repeat (40) @(negedge clk);
    chk("t2 core_rst", 32'(core_rst), 32'd0);
    chk("t2 done", 32'(done), 32'd0);
    chk("t2 in_ready", 32'(bus.in_ready), 32'd0);
    check_log("t2", 3);
    pulse_reload();
    chk("t2 reload in_ready", 32'(bus.in_ready), 32'd1);
    chk("t2 reload error", 32'(error), 32'd0);

    // 3: illegal lengths
    clear_log();
    send_byte(8'h00);
    end_frame();
    chk("t3 len0 error", 32'(error), 32'd1);
    pulse_reload();
    send_byte(8'h21);
    end_frame();
    chk("t3 len33 error", 32'(error), 32'd1);
    repeat (5) @(negedge clk);
    chk("t3 writes", 32'(wr_addr.size()), 32'd0);
    pulse_reload();

    // 4: full-depth frame, checksum wraps
    clear_log();
    s = 8'h00;
    send_byte(8'h20);
    for (int i = 0; i < 32; i++) begin
      d = 8'(i * 37 + 200);
      exp_mem[i] = d;
      s = s + d;
      send_byte(d);
    end
    send_byte(s);
    end_frame();
    wait_done("t4 done");
    check_log("t4", 32);
    pulse_reload();

    // 5: gappy valid during LOAD
    clear_log();
    exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'h33;
    exp_mem[3] = 8'h44; exp_mem[4] = 8'h55;
    send_byte(8'h05);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(exp_mem[i]);
    end
    send_byte(8'hFF);
    end_frame();
    wait_done("t5 done");
    check_log("t5", 32);
    pulse_reload();

    // 6: reset mid-load, then fresh frame
    send_byte(8'h04); send_byte(8'h77); send_byte(8'h88);
    end_frame();
    rst = 1'b0;
    @(negedge clk);
    chk("t6 rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("t6 rst core_rst", 32'(core_rst), 32'd0);
    chk("t6 rst ms_write", 32'(bus.ms_write), 32'd0);
    rst = 1'b1;
    clear_log();
    exp_mem[0] = 8'h5A; exp_mem[1] = 8'hA5;
    send_byte(8'h02); send_byte(8'h5A); send_byte(8'hA5); send_byte(8'hFF);
    end_frame();
    wait_done("t6 done");
    chk("t6 core_rst", 32'(core_rst), 32'd1);
    check_log("t6", 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
